ttc_apb_if_lite12: RTL
======================

// Module: ttc_apb_if_lite12
// PURPOSE
//  APB slave front-end for one lite TTC timer; sits directly upstream of ttc_timer_counter_lite12.
//  Decodes APB transfers into one-cycle register write strobes, drives pwdata to the timer,
//  and muxes timer register outputs onto a registered prdata.
//  Issues clear_interrupt12 after the interrupt status register has been read.
// PARAMETERS
//  ADDR_W      8  APB address width; only paddr12[5:2] decoded, upper bits must be 0 for a hit
//  CLR_ON_READ 1  1: reading INT_STS pulses clear_interrupt12; 0: never pulses
// PORTS
//  pclk12              in   1   APB clock, all state on rising edge
//  p_reset12           in   1   asynchronous, active-high reset
//  psel12              in   1   APB select
//  penable12           in   1   APB enable (access phase)
//  pwrite12            in   1   1 write, 0 read
//  paddr12             in   ADDR_W byte address
//  pwdata12            in   16  APB write data (lower 16 bits of bus)
//  prdata12            out  16  read data, registered
//  pready12            out  1   tied 1 (no wait states)
//  pslverr12           out  1   error on unmapped/illegal access, access phase only
//  pwdata_out12        out  16  write data to timer, registered
//  clk_ctrl_reg_sel12, cntr_ctrl_reg_sel12, interval_reg_sel12, match_1_reg_sel12,
//  match_2_reg_sel12, match_3_reg_sel12, intr_en_reg_sel12  out 1 each  write strobes
//  clear_interrupt12   out  1   interrupt clear pulse
//  clk_ctrl_reg12 in 7, cntr_ctrl_reg12 in 7, counter_val_reg12 in 16, interval_reg12 in 16,
//  match_1/2/3_reg12 in 16 each, interrupt_reg12 in 6, interrupt_en_reg12 in 6  readback
// BEHAVIOUR
//  Map (paddr[7:0]): 00 CLK_CTRL rw, 04 CNTR_CTRL rw, 08 COUNT ro, 0C INTERVAL rw, 10 MATCH1 rw,
//   14 MATCH2 rw, 18 MATCH3 rw, 1C INT_STS ro, 20 INT_EN rw; unused read bits return 0.
//  FSM IDLE->SETUP (psel&!penable) ->ACCESS (psel&penable) ->IDLE, or ->SETUP if next cycle is
//   psel&!penable (back-to-back). penable without a preceding SETUP: ignored, no strobe, no error.
//  Write: in SETUP cycle with hit on rw reg, strobe and pwdata_out12 are registered; strobe is high
//   exactly the ACCESS cycle (1 pclk), pwdata_out12 holds value until next write. One-hot strobes.
//  Read: prdata12 registered in SETUP from mux, valid in ACCESS, held until next read SETUP.
//  clear_interrupt12: high 1 cycle after ACCESS of a read to 1C (CLR_ON_READ=1), so read value is
//   the pre-clear status; simultaneous new interrupt event is the timer's concern.
//  pslverr12=1 in ACCESS for: unmapped offset, paddr[1:0]!=0, upper bits nonzero, write to 08/1C.
//   Error writes produce no strobe; error reads return 0000, no clear.
//  pready12 constant 1. psel dropped mid-transfer: FSM to IDLE, pending strobe/clear suppressed.
//  Reset (async assert, any cycle): FSM IDLE, prdata12=0, pwdata_out12=0, all strobes=0,
//   clear_interrupt12=0, pslverr12=0; first transfer accepted cycle after deassertion.
// TESTING
//  Write 0x1234 to 0C -> interval_reg_sel12 high exactly ACCESS cycle, pwdata_out12=0x1234, no err.
//  Read 08 with counter_val_reg12=0xBEEF -> prdata12=0xBEEF in ACCESS, no strobe, no clear.
//  Read 1C, interrupt_reg12=6'h05 -> prdata12=0x0005, clear_interrupt12 1 cycle after ACCESS.
//  Write 08 and read 0x24 -> pslverr12=1, no strobe, prdata12=0.
//  Back-to-back write 00 (0x7F) then write 20 (0x3F) -> two 1-cycle strobes 2 cycles apart.
//  Assert p_reset12 during SETUP of write to 10 -> no match_1_reg_sel12 pulse, outputs all 0.

Source files
------------

// File: rtl/ttc_apb_if_lite12.sv
// APB slave front-end for a lite TTC timer: decodes transfers into one-cycle
// register write strobes, registers write data and read data, and pulses an interrupt clear.
module ttc_apb_if_lite12 #(
  parameter int unsigned ADDR_W      = 8,
  parameter bit          CLR_ON_READ = 1'b1
) (
  input  logic              pclk12,
  input  logic              p_reset12,
  input  logic              psel12,
  input  logic              penable12,
  input  logic              pwrite12,
  input  logic [ADDR_W-1:0] paddr12,
  input  logic [15:0]       pwdata12,
  output logic [15:0]       prdata12,
  output logic              pready12,
  output logic              pslverr12,
  output logic [15:0]       pwdata_out12,
  output logic              clk_ctrl_reg_sel12,
  output logic              cntr_ctrl_reg_sel12,
  output logic              interval_reg_sel12,
  output logic              match_1_reg_sel12,
  output logic              match_2_reg_sel12,
  output logic              match_3_reg_sel12,
  output logic              intr_en_reg_sel12,
  output logic              clear_interrupt12,
  input  logic [6:0]        clk_ctrl_reg12,
  input  logic [6:0]        cntr_ctrl_reg12,
  input  logic [15:0]       counter_val_reg12,
  input  logic [15:0]       interval_reg12,
  input  logic [15:0]       match_1_reg12,
  input  logic [15:0]       match_2_reg12,
  input  logic [15:0]       match_3_reg12,
  input  logic [5:0]        interrupt_reg12,
  input  logic [5:0]        interrupt_en_reg12
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t      state_q, state_d;
  logic [6:0]  strb_q, strb_d;
  logic [15:0] pwdata_q, pwdata_d;
  logic [15:0] prdata_q, prdata_d;
  logic        err_q, err_d;
  logic        rdclr_q, rdclr_d;
  logic        clr_q, clr_d;

  logic        setup_c, access_c;
  logic [3:0]  idx;
  logic        addr_ok, mapped, read_only, err_c;
  logic [15:0] rmux;
  logic [6:0]  wsel;

  assign setup_c  = psel12 && !penable12;
  // An access phase only counts when it directly follows a recognised setup phase.
  assign access_c = psel12 && penable12 && (state_q == SETUP);

  assign idx       = paddr12[5:2];
  assign addr_ok   = (paddr12[1:0] == 2'b00) && ((paddr12 >> 6) == '0);
  assign mapped    = (idx <= 4'd8);
  assign read_only = (idx == 4'd2) || (idx == 4'd7);
  assign err_c     = !addr_ok || !mapped || (pwrite12 && read_only);

  always_comb begin
    rmux = '0;
    wsel = '0;
    case (idx)
      4'd0: begin rmux = {9'd0, clk_ctrl_reg12};  wsel = 7'b0000001; end
      4'd1: begin rmux = {9'd0, cntr_ctrl_reg12}; wsel = 7'b0000010; end
      4'd2: rmux = counter_val_reg12;
      4'd3: begin rmux = interval_reg12;          wsel = 7'b0000100; end
      4'd4: begin rmux = match_1_reg12;           wsel = 7'b0001000; end
      4'd5: begin rmux = match_2_reg12;           wsel = 7'b0010000; end
      4'd6: begin rmux = match_3_reg12;           wsel = 7'b0100000; end
      4'd7: rmux = {10'd0, interrupt_reg12};
      4'd8: begin rmux = {10'd0, interrupt_en_reg12}; wsel = 7'b1000000; end
      default: begin rmux = '0; wsel = '0; end
    endcase
  end

  always_comb begin
    state_d  = IDLE;
    strb_d   = '0;
    pwdata_d = pwdata_q;
    prdata_d = prdata_q;
    err_d    = setup_c && err_c;
    rdclr_d  = 1'b0;
    clr_d    = access_c && rdclr_q;
    if (setup_c) begin
      state_d = SETUP;
      if (pwrite12) begin
        if (!err_c) begin
          strb_d   = wsel;
          pwdata_d = pwdata12;
        end
      end else begin
        prdata_d = err_c ? '0 : rmux;
        rdclr_d  = CLR_ON_READ && !err_c && (idx == 4'd7);
      end
    end else if (access_c) begin
      state_d = ACCESS;
    end
  end

  always_ff @(posedge pclk12 or posedge p_reset12) begin
    if (p_reset12) begin
      state_q  <= IDLE;
      strb_q   <= '0;
      pwdata_q <= '0;
      prdata_q <= '0;
      err_q    <= 1'b0;
      rdclr_q  <= 1'b0;
      clr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      strb_q   <= strb_d;
      pwdata_q <= pwdata_d;
      prdata_q <= prdata_d;
      err_q    <= err_d;
      rdclr_q  <= rdclr_d;
      clr_q    <= clr_d;
    end
  end

  // Registered strobe/error are qualified by the live access phase so a dropped psel kills them.
  assign clk_ctrl_reg_sel12  = strb_q[0] && access_c;
  assign cntr_ctrl_reg_sel12 = strb_q[1] && access_c;
  assign interval_reg_sel12  = strb_q[2] && access_c;
  assign match_1_reg_sel12   = strb_q[3] && access_c;
  assign match_2_reg_sel12   = strb_q[4] && access_c;
  assign match_3_reg_sel12   = strb_q[5] && access_c;
  assign intr_en_reg_sel12   = strb_q[6] && access_c;
  assign pslverr12           = err_q && access_c;
  assign pready12            = 1'b1;
  assign prdata12            = prdata_q;
  assign pwdata_out12        = pwdata_q;
  assign clear_interrupt12   = clr_q;

endmodule
